// File: rtl/instr_fetch_ir.sv
// Instruction fetch and instruction register behind the jump control unit.
// Issues reads to a 1-cycle synchronous ROM and holds the result for decode, using a one-entry skid buffer and flush.
module instr_fetch_ir #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_Address_Instruction_Bus,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_rom_en,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic               o_pc_advance,
  output logic               o_instr_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [3:0]         o_opcode,
  output logic [3:0]         o_cond,
  output logic [7:0]         o_imm
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
  } entry_t;

  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic              skid_v;
  entry_t            skid;
  logic              ir_v;
  entry_t            ir;
  logic              rom_en;

  // A flush always refetches. Otherwise a request is issued only when the
  // downstream path can take the response: no stall and an empty skid buffer.
  assign rom_en       = rst & (i_flush | (~i_stall & ~skid_v));
  assign o_rom_en     = rom_en;
  assign o_pc_advance = rom_en;
  assign o_rom_addr   = i_Address_Instruction_Bus;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here; every branch below reads the
    // pre-edge values of pend_v/skid_v/ir_v, which is what the priority relies on.
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      skid_v    <= 1'b0;
      ir_v      <= 1'b0;
      // NOTE: the data registers are cleared too, not only the valid bits.
      // The field outputs are wired straight from ir, so they must read zero
      // during reset.
      ir        <= '0;
      skid      <= '0;
    end else begin
      pend_v <= rom_en;
      if (rom_en) pend_addr <= i_Address_Instruction_Bus;

      if (i_flush) begin
        ir_v   <= 1'b0;
        skid_v <= 1'b0;
      end else if (!i_stall && skid_v) begin
        ir     <= skid;
        ir_v   <= 1'b1;
        skid_v <= 1'b0;
      end else if (pend_v && (!ir_v || !i_stall)) begin
        ir.data <= i_rom_data;
        ir.pc   <= pend_addr;
        ir_v    <= 1'b1;
      end else if (pend_v && ir_v && i_stall) begin
        skid.data <= i_rom_data;
        skid.pc   <= pend_addr;
        skid_v    <= 1'b1;
      end else if (!pend_v && !i_stall) begin
        ir_v <= 1'b0;
      end
    end
  end

  assign o_instr_valid = ir_v;
  assign o_instr       = ir.data;
  assign o_pc          = ir.pc;
  assign o_opcode      = ir.data[15:12];
  assign o_cond        = ir.data[11:8];
  assign o_imm         = ir.data[7:0];

endmodule

// File: tb/tb_instr_fetch_ir.sv
// Directed bench for instr_fetch_ir. A behavioural ROM returns the word
// {4'hA, 4'h1, addr}, and a simple UCJ stand-in advances the address on o_pc_advance.
module tb_instr_fetch_ir;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        stall;
  logic        flush;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        pc_advance;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [3:0]  opcode;
  logic [3:0]  cond;
  logic [7:0]  imm;

  int vectors;
  int miscompares;

  instr_fetch_ir #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .i_Address_Instruction_Bus (addr),
    .i_stall                   (stall),
    .i_flush                   (flush),
    .o_rom_en                  (rom_en),
    .o_rom_addr                (rom_addr),
    .i_rom_data                (rom_data),
    .o_pc_advance              (pc_advance),
    .o_instr_valid             (instr_valid),
    .o_instr                   (instr),
    .o_pc                      (pc),
    .o_opcode                  (opcode),
    .o_cond                    (cond),
    .o_imm                     (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    return {4'hA, 4'h1, a};
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  // One clock. The advance is sampled on the falling edge, the UCJ address is
  // stepped after the rising edge, and outputs are then read 1 ns past the edge.
  task automatic tick();
    logic adv;
    @(negedge clk);
    adv = pc_advance;
    @(posedge clk);
    #1;
    if (adv) addr = addr + 8'h01;
  endtask

  task automatic expect_ir(input string name, input logic v, input logic [7:0] p);
    vectors++;
    if (instr_valid !== v || (v && (pc !== p || instr !== rom_word(p)))) begin
      miscompares++;
      $display("FAIL %s: valid=%b pc=%h instr=%h, want valid=%b pc=%h instr=%h",
               name, instr_valid, pc, instr, v, p, rom_word(p));
    end
  endtask

  task automatic expect_en(input string name, input logic e);
    vectors++;
    if (rom_en !== e || pc_advance !== e) begin
      miscompares++;
      $display("FAIL %s: rom_en=%b pc_advance=%b, want %b", name, rom_en, pc_advance, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; addr = 8'h00;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({instr_valid, instr, pc, opcode, cond, imm} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: valid=%b instr=%h pc=%h op=%h cond=%h imm=%h, want all 0",
                 instr_valid, instr, pc, opcode, cond, imm);
      end
      expect_en("reset_rom_en", 1'b0);
    end
    rst = 1'b1;
    #1;
    expect_en("release_rom_en", 1'b1);
    vectors++;
    if (rom_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL release_rom_addr: got %h, want 00", rom_addr);
    end
  endtask

  task automatic test_streaming();
    tick();
    expect_ir("stream_latency", 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_ir("stream_word", 1'b1, 8'(i));
      vectors++;
      if (opcode !== 4'hA || cond !== 4'h1 || imm !== 8'(i)) begin
        miscompares++;
        $display("FAIL stream_fields: op=%h cond=%h imm=%h, want A/1/%h", opcode, cond, imm, 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    tick();
    expect_ir("stall_pre", 1'b1, 8'h04);
    stall = 1'b1;
    #1;
    expect_en("stall_rom_en", 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_ir("stall_hold", 1'b1, 8'h04);
      expect_en("stall_rom_en", 1'b0);
    end
    tick();
    expect_ir("stall_hold", 1'b1, 8'h04);
    stall = 1'b0;
    #1;
    expect_en("skid_full_rom_en", 1'b0);
    tick();
    expect_ir("skid_drain", 1'b1, 8'h05);
    expect_en("drain_rom_en", 1'b1);
    tick();
    expect_ir("drain_bubble", 1'b0, 8'h00);
    tick();
    expect_ir("after_bubble", 1'b1, 8'h06);
  endtask

  task automatic test_flush();
    addr = 8'h10;
    tick();
    expect_ir("flush_pre1", 1'b1, 8'h07);
    tick();
    expect_ir("flush_pre2", 1'b1, 8'h10);
    flush = 1'b1;
    addr  = 8'hF0;
    #1;
    expect_en("flush_rom_en", 1'b1);
    tick();
    flush = 1'b0;
    expect_ir("flush_gap", 1'b0, 8'h00);
    tick();
    expect_ir("flush_target", 1'b1, 8'hF0);
    tick();
    expect_ir("flush_next", 1'b1, 8'hF1);
  endtask

  task automatic test_flush_stall();
    stall = 1'b1;
    tick();
    expect_ir("fs_fill_skid", 1'b1, 8'hF1);
    flush = 1'b1;
    addr  = 8'h40;
    #1;
    expect_en("fs_rom_en", 1'b1);
    tick();
    flush = 1'b0;
    expect_ir("fs_gap", 1'b0, 8'h00);
    #1;
    expect_en("fs_stalled_rom_en", 1'b0);
    tick();
    expect_ir("fs_target", 1'b1, 8'h40);
    tick();
    expect_ir("fs_hold", 1'b1, 8'h40);
    stall = 1'b0;
  endtask

  task automatic test_wrap_reset();
    addr = 8'hFE;
    tick();
    expect_ir("wrap_consume", 1'b0, 8'h00);
    tick();
    expect_ir("wrap_fe", 1'b1, 8'hFE);
    tick();
    expect_ir("wrap_ff", 1'b1, 8'hFF);
    tick();
    expect_ir("wrap_00", 1'b1, 8'h00);
    rst = 1'b0;
    #1;
    expect_en("midreset_rom_en", 1'b0);
    tick();
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 16'h0000 || pc !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset_clear: valid=%b instr=%h pc=%h, want 0/0000/00", instr_valid, instr, pc);
    end
    rst = 1'b1;
    tick();
    expect_ir("midreset_drop", 1'b0, 8'h00);
    tick();
    expect_ir("midreset_resume", 1'b1, 8'h02);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rom_data    = '0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
